// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider math.
// Used by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Clocks per oversample tick, truncated.
  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-clock tick every DIV enabled clocks.
// Ports: clk, arst, rst, en (count enable), clr (hold at 0), tick (pulse).
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic arst,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_baud_tick: DIV must be >= 1");
  end

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises rx, samples bits at centre, holds byte on valid/ready.
// Ports: clk, arst, rst, en, rx in; data_o/valid_o/ready_i byte handshake; error pulses; busy_o.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          P_ODD  = (PARITY_ODD != 0);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx_deserializer: OVERSAMPLE must be even and >= 8");
  end

  rx_state_t            state;
  logic                 rx_m;
  logic                 rx_s;
  logic                 rx_d;
  logic                 fall;
  logic                 tick;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh;
  logic                 perr;

  // rx_d trails rx_s so a start edge is a true 1->0 transition;
  // a held break therefore never re-triggers START.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d && !rx_s;

  // Held clear in IDLE so the first tick of START lands DIV clocks after the edge.
  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .arst (arst),
    .rst  (rst),
    .en   (en),
    .clr  (state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      scnt         <= '0;
      bcnt         <= '0;
      sh           <= '0;
      perr         <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else if (rst) begin
      state        <= IDLE;
      scnt         <= '0;
      bcnt         <= '0;
      sh           <= '0;
      perr         <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;
      if (!en) begin
        state <= IDLE;
        scnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fall) begin
              state <= START;
              scnt  <= '0;
            end
          end
          START: begin
            if (tick) begin
              if (scnt == S_MID) begin
                scnt  <= '0;
                bcnt  <= '0;
                perr  <= 1'b0;
                state <= rx_s ? IDLE : DATA;
              end else begin
                scnt <= scnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (tick) begin
              if (scnt == S_END) begin
                scnt <= '0;
                sh   <= {rx_s, sh[DATA_BITS-1:1]};
                bcnt <= bcnt + 1'b1;
                if (bcnt == B_LAST)
                  state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                scnt <= scnt + 1'b1;
              end
            end
          end
          PARITY: begin
            if (tick) begin
              if (scnt == S_END) begin
                scnt  <= '0;
                perr  <= rx_s ^ (^sh) ^ P_ODD;
                state <= STOP;
              end else begin
                scnt <= scnt + 1'b1;
              end
            end
          end
          STOP: begin
            if (tick) begin
              if (scnt == S_END) begin
                scnt  <= '0;
                state <= IDLE;
                if (!rx_s) begin
                  frame_err_o <= 1'b1;
                end else if (!valid_o || ready_i) begin
                  data_o       <= sh;
                  valid_o      <= 1'b1;
                  parity_err_o <= perr;
                end else begin
                  overrun_o <= 1'b1;
                end
              end else begin
                scnt <= scnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: 8N1 and 8E1 instances, directed and random frames.
// Frames are built bit by bit from the line format; expectations come from byte values.
module tb_uart_rx_deserializer;

  localparam int CLK_HZ = 1_600_000;
  localparam int BR     = 10_000;
  localparam int OS     = 16;
  localparam int BITCLK = CLK_HZ / BR;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic       rxp = 1'b1;
  logic       ready = 1'b1;
  logic       readyp = 1'b1;
  logic [7:0] data;
  logic       valid, perr, ferr, ovr, busy;
  logic [7:0] datap;
  logic       validp, perrp, ferrp, ovrp, busyp;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BR),
    .OVERSAMPLE  (OS),
    .DATA_BITS   (8),
    .PARITY_EN   (0),
    .PARITY_ODD  (0)
  ) u_dut (
    .clk          (clk),
    .arst         (arst),
    .rst          (rst),
    .en           (en),
    .rx           (rx),
    .data_o       (data),
    .valid_o      (valid),
    .ready_i      (ready),
    .parity_err_o (perr),
    .frame_err_o  (ferr),
    .overrun_o    (ovr),
    .busy_o       (busy)
  );

  uart_rx_deserializer #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BR),
    .OVERSAMPLE  (OS),
    .DATA_BITS   (8),
    .PARITY_EN   (1),
    .PARITY_ODD  (0)
  ) u_par (
    .clk          (clk),
    .arst         (arst),
    .rst          (rst),
    .en           (en),
    .rx           (rxp),
    .data_o       (datap),
    .valid_o      (validp),
    .ready_i      (readyp),
    .parity_err_o (perrp),
    .frame_err_o  (ferrp),
    .overrun_o    (ovrp),
    .busy_o       (busyp)
  );

  // Event monitors: new bytes on valid rising edge, pulse counters.
  int got_q[$];
  int gotp_q[$];
  int gotp_e[$];
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  int n_ferrp = 0, n_ovrp = 0;
  int vcnt = 0, last_vlen = 0;
  logic pv = 1'b0, pvp = 1'b0;

  always @(negedge clk) begin
    pv  <= valid;
    pvp <= validp;
    if (valid && !pv) got_q.push_back(int'(data));
    if (validp && !pvp) begin
      gotp_q.push_back(int'(datap));
      gotp_e.push_back(int'(perrp));
    end
    if (ferr)  n_ferr  <= n_ferr + 1;
    if (ovr)   n_ovr   <= n_ovr + 1;
    if (perr)  n_perr  <= n_perr + 1;
    if (ferrp) n_ferrp <= n_ferrp + 1;
    if (ovrp)  n_ovrp  <= n_ovrp + 1;
    if (valid) vcnt <= vcnt + 1;
    else if (pv) begin
      last_vlen <= vcnt;
      vcnt      <= 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(input bit sel, input logic v);
    if (sel) rxp = v;
    else     rx  = v;
  endtask

  // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send(input bit sel, input logic [7:0] d,
                      input int par, input logic stopb);
    drv(sel, 1'b0);
    wait_clk(BITCLK);
    for (int i = 0; i < 8; i++) begin
      drv(sel, d[i]);
      wait_clk(BITCLK);
    end
    if (par >= 0) begin
      drv(sel, par[0]);
      wait_clk(BITCLK);
    end
    drv(sel, stopb);
    wait_clk(BITCLK);
  endtask

  task automatic idle(input bit sel, input int n);
    drv(sel, 1'b1);
    wait_clk(n);
  endtask

  initial begin
    int b, bp, f0, o0;
    int exp_q[$];
    int expp_q[$];
    int expe_q[$];
    logic [7:0] d;
    int wrong;

    wait_clk(4);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_perr", int'(perr), 0);
    check("rst_ferr", int'(ferr), 0);
    check("rst_ovr", int'(ovr), 0);
    arst = 1'b0;
    wait_clk(20);

    // 1: plain 8N1 frame
    b = got_q.size();
    send(0, 8'hA5, -1, 1'b1);
    idle(0, 200);
    check("t1_cnt", got_q.size() - b, 1);
    check("t1_data", qget(got_q, b), 'hA5);
    check("t1_vlen", last_vlen, 1);
    check("t1_ferr", n_ferr, 0);
    check("t1_busy", int'(busy), 0);

    // 2: short glitch is a false start
    b = got_q.size();
    rx = 1'b0;
    wait_clk(48);
    idle(0, 400);
    check("t2_cnt", got_q.size() - b, 0);
    check("t2_busy", int'(busy), 0);
    check("t2_flags", n_ferr + n_ovr + n_perr, 0);

    // 3: even parity, wrong parity bit, byte still delivered
    bp = gotp_q.size();
    send(1, 8'h03, 1, 1'b1);
    idle(1, 200);
    check("t3_cnt", gotp_q.size() - bp, 1);
    check("t3_data", qget(gotp_q, bp), 'h03);
    check("t3_perr", qget(gotp_e, bp), 1);

    // 4: framing error then a long break
    b = got_q.size();
    f0 = n_ferr;
    send(0, 8'h55, -1, 1'b0);
    rx = 1'b0;
    wait_clk(2000);
    check("t4_ferr", n_ferr - f0, 1);
    check("t4_busy", int'(busy), 0);
    idle(0, 400);
    check("t4_cnt", got_q.size() - b, 0);
    check("t4_ferr2", n_ferr - f0, 1);

    // 5: overrun with consumer stalled
    b = got_q.size();
    o0 = n_ovr;
    ready = 1'b0;
    send(0, 8'h11, -1, 1'b1);
    send(0, 8'h22, -1, 1'b1);
    idle(0, 100);
    check("t5_cnt", got_q.size() - b, 1);
    check("t5_data", int'(data), 'h11);
    check("t5_ovr", n_ovr - o0, 1);
    check("t5_valid", int'(valid), 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_fall", int'(valid), 0);
    check("t5_hold", int'(data), 'h11);
    wait_clk(20);

    // en dropped mid-frame: frame discarded, no flags
    b = got_q.size();
    f0 = n_ferr;
    rx = 1'b0;
    wait_clk(3 * BITCLK);
    en = 1'b0;
    wait_clk(2);
    check("en_busy", int'(busy), 0);
    wait_clk(3);
    en = 1'b1;
    wait_clk(2 * BITCLK);
    rx = 1'b1;
    wait_clk(5 * BITCLK);
    idle(0, 300);
    check("en_cnt", got_q.size() - b, 0);
    check("en_ferr", n_ferr - f0, 0);

    // 6: async reset mid data, then back-to-back frames
    rx = 1'b0;
    wait_clk(BITCLK);
    rx = 1'b1;
    wait_clk(2 * BITCLK);
    arst = 1'b1;
    wait_clk(3);
    check("t6_rbusy", int'(busy), 0);
    check("t6_rvalid", int'(valid), 0);
    check("t6_rdata", int'(data), 0);
    arst = 1'b0;
    wait_clk(7 * BITCLK);
    b = got_q.size();
    send(0, 8'h3C, -1, 1'b1);
    send(0, 8'hC3, -1, 1'b1);
    idle(0, 200);
    check("t6_cnt", got_q.size() - b, 2);
    check("t6_d0", qget(got_q, b), 'h3C);
    check("t6_d1", qget(got_q, b + 1), 'hC3);

    // random 8N1 frames, random gaps
    b = got_q.size();
    exp_q = {};
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      exp_q.push_back(int'(d));
      send(0, d, -1, 1'b1);
      idle(0, $urandom_range(0, 300));
    end
    idle(0, 200);
    check("r_cnt", got_q.size() - b, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("r_d%0d", i), qget(got_q, b + i), exp_q[i]);

    // random 8E1 frames with randomly corrupted parity
    bp = gotp_q.size();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      wrong = int'($urandom_range(0, 1));
      expp_q.push_back(int'(d));
      expe_q.push_back(wrong);
      send(1, d, int'(^d) ^ wrong, 1'b1);
      idle(1, $urandom_range(0, 300));
    end
    idle(1, 200);
    check("rp_cnt", gotp_q.size() - bp, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rp_d%0d", i), qget(gotp_q, bp + i), expp_q[i]);
      check($sformatf("rp_e%0d", i), qget(gotp_e, bp + i), expe_q[i]);
    end

    check("p_ferr", n_ferrp, 0);
    check("p_ovr", n_ovrp, 0);
    check("p_busy", int'(busyp), 0);
    check("m_perr", n_perr, 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
